// File: rtl/up_counter_mod.sv
// rtl/up_counter_mod.sv - programmable-limit up counter with wrap / one-shot modes
//
// Purpose:
//   Period/interval timer that counts up from 0 (or a loaded value) to a
//   runtime limit. At the limit it either wraps to 0 (mode=0) or stops and
//   holds (mode=1). It is the counting-up partner of the library's down counter.
//
// Ports:
//   i_clk        system clock, rising-edge active
//   i_reset      asynchronous active-high reset
//   i_enable     count-advance enable
//   i_load       synchronous load strobe (wins over counting)
//   i_load_value value written to the count on load
//   i_limit      terminal value, compared every cycle
//   i_mode       0 = wrap (free-running), 1 = one-shot (stop at limit)
//   i_clear_ovf  synchronous clear of the overflow flag
//   o_count      current count (registered)
//   o_tc         one-cycle terminal-count pulse (registered)
//   o_done       sticky one-shot finished flag (registered)
//   o_ovf        sticky wrap-occurred flag (registered)

module up_counter_mod #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_mode,
  input  logic             i_clear_ovf,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_done,
  output logic             o_ovf
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;
  logic             r_ovf;

  // ">=" rather than "==" so that a loaded value, or a lowered limit, that
  // is already past the limit still produces a terminal event instead of
  // counting up through the modulo-2^WIDTH boundary.
  logic w_terminal;
  assign w_terminal = (r_count >= i_limit);

  // The increment is only taken when r_count < i_limit, so it can never
  // overflow the WIDTH-bit register.
  logic [WIDTH-1:0] w_count_inc;
  assign w_count_inc = r_count + {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // Clear first; a wrap on the same edge assigns 1 later in this block
      // and therefore takes precedence.
      if (i_clear_ovf) begin
        r_ovf <= 1'b0;
      end

      if (i_load) begin
        r_count <= i_load_value;
        r_state <= ST_RUN;
        r_done  <= 1'b0;
        r_tc    <= 1'b0;
      end else if ((r_state == ST_RUN) && i_enable) begin
        if (!w_terminal) begin
          r_count <= w_count_inc;
          r_tc    <= 1'b0;
        end else if (!i_mode) begin
          r_count <= '0;
          r_tc    <= 1'b1;
          r_ovf   <= 1'b1;
        end else begin
          // One-shot: the count freezes at its terminal value.
          r_tc    <= 1'b1;
          r_done  <= 1'b1;
          r_state <= ST_HOLD;
        end
      end else begin
        r_tc <= 1'b0;
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_done  = r_done;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_up_counter_mod.sv
// tb/tb_up_counter_mod.sv - self-checking bench for up_counter_mod
//
// Drives directed scenarios followed by randomized stimulus. A behavioural
// model tracks count/tc/done/ovf from the counter's rules; the compare process
// checks the DUT against it on every falling edge. Literal checks pin the
// model in the directed scenarios.

module tb_up_counter_mod;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic             clear_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;
  logic             ovf;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  up_counter_mod #(.WIDTH(WIDTH)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_load       (load),
    .i_load_value (load_value),
    .i_limit      (limit),
    .i_mode       (mode),
    .i_clear_ovf  (clear_ovf),
    .o_count      (count),
    .o_tc         (tc),
    .o_done       (done),
    .o_ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A one-shot counter is stopped exactly while its done flag is set, so the
  // model uses done as the "stopped" indicator rather than tracking a state.
  int m_count;
  bit m_tc, m_done, m_ovf;
  bit m_wrap;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = 0;
      m_tc    = 0;
      m_done  = 0;
      m_ovf   = 0;
    end else begin
      m_wrap = 0;
      m_tc   = 0;
      if (load) begin
        m_count = int'(load_value);
        m_done  = 0;
      end else if (enable && !m_done) begin
        if (m_count < int'(limit)) begin
          m_count = m_count + 1;
        end else begin
          m_tc = 1;
          if (mode) m_done = 1;
          else begin
            m_count = 0;
            m_wrap  = 1;
          end
        end
      end
      if (m_wrap) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (int'(count) != m_count || tc != m_tc || done != m_done || ovf != m_ovf) begin
        n_bad++;
        $display("FAIL model t=%0t got count=%0d tc=%0b done=%0b ovf=%0b expected count=%0d tc=%0b done=%0b ovf=%0b",
                 $time, count, tc, done, ovf, m_count, m_tc, m_done, m_ovf);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int exp_count, input bit exp_tc,
                       input bit exp_done, input bit exp_ovf);
    n_cmp++;
    if (int'(count) != exp_count || tc != exp_tc || done != exp_done || ovf != exp_ovf) begin
      n_bad++;
      $display("FAIL %s got count=%0d tc=%0b done=%0b ovf=%0b expected count=%0d tc=%0b done=%0b ovf=%0b",
               name, count, tc, done, ovf, exp_count, exp_tc, exp_done, exp_ovf);
    end
  endtask

  task automatic do_load(input int v);
    load       = 1'b1;
    load_value = WIDTH'(v);
    tick();
    load       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    load       = 1'b0;
    load_value = '0;
    limit      = 4'd9;
    mode       = 1'b0;
    clear_ovf  = 1'b0;

    #3;
    check("reset_async_initial", 0, 0, 0, 0);
    tick();                       // t=10
    reset  = 1'b0;
    chk_en = 1'b1;

    // Wrap counting, limit 9.
    enable = 1'b1;
    repeat (9) tick();
    check("wrap_at_9", 9, 0, 0, 0);
    tick();
    check("wrap_to_0", 0, 1, 0, 1);
    tick();
    check("wrap_then_1", 1, 0, 0, 1);

    // One-shot, limit 5.
    mode  = 1'b1;
    limit = 4'd5;
    do_load(0);
    check("oneshot_load0", 0, 0, 0, 1);
    repeat (5) tick();
    check("oneshot_at_5", 5, 0, 0, 1);
    tick();
    check("oneshot_tc", 5, 1, 1, 1);
    repeat (10) tick();
    check("oneshot_hold", 5, 0, 1, 1);
    do_load(2);
    check("oneshot_reload", 2, 0, 0, 1);
    repeat (3) tick();
    check("oneshot_rerun_5", 5, 0, 0, 1);
    tick();
    check("oneshot_redone", 5, 1, 1, 1);

    // Load beats enable; full-range wrap.
    mode  = 1'b0;
    limit = 4'd15;
    do_load(12);
    check("prio_load12", 12, 0, 0, 1);
    repeat (3) tick();
    check("prio_15", 15, 0, 0, 1);
    tick();
    check("prio_full_wrap", 0, 1, 0, 1);

    // Asynchronous reset mid-cycle at count 7.
    do_load(7);
    enable = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", 0, 0, 0, 0);
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    check("after_reset_1", 1, 0, 0, 0);

    // Sticky overflow.
    limit = 4'd3;
    do_load(3);
    clear_ovf = 1'b1;
    tick();
    check("ovf_set_wins", 0, 1, 0, 1);
    tick();
    check("ovf_cleared", 1, 0, 0, 0);
    clear_ovf = 1'b0;
    do_load(5);
    tick();
    check("ovf_above_limit", 0, 1, 0, 1);
    do_load(1);
    check("ovf_load_keeps", 1, 0, 0, 1);

    // limit 0, wrap mode.
    limit = 4'd0;
    do_load(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("lim0_wrap", 0, 1, 0, 1);
    end

    // Loaded value above limit.
    limit = 4'd4;
    do_load(10);
    tick();
    check("load10_lim4", 0, 1, 0, 1);

    // Enable low freezes count.
    do_load(2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("enable_low", 2, 0, 0, 1);
    end

    // limit 0, one-shot; mode change while holding.
    enable = 1'b1;
    limit  = 4'd0;
    mode   = 1'b1;
    do_load(0);
    tick();
    check("lim0_oneshot", 0, 1, 1, 1);
    mode = 1'b0;
    tick();
    check("hold_mode_change", 0, 0, 1, 1);

    // Randomized stimulus, inputs change 2 time units after each rising edge.
    @(posedge clk);
    for (int i = 0; i < 3000; i++) begin
      #2;
      reset      = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_value = WIDTH'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      mode       = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      clear_ovf  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) limit = WIDTH'($urandom);
      @(posedge clk);
    end
    #2 reset = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/up_counter_mod.md
Name: up_counter_mod

Overview:
Programmable-limit up counter. It is the counting-up counterpart to the team's existing down counter and is used as a period/interval timer.
- Counts from 0 (or a loaded value) up to a runtime limit.
- At the limit, either wraps to 0 or stops, depending on mode.
- Flags: one-cycle terminal-count pulse, sticky done flag (one-shot), sticky overflow flag (wrap).
- Single clock domain; sits beside the down counter in the timer/counter library.

Parameters:
WIDTH, 4, bit width of count, load_value and limit.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
enable  input  1  count-advance enable, sampled on rising clk
load  input  1  synchronous load strobe; highest priority after reset
load_value  input  WIDTH  value written to count on load
limit  input  WIDTH  terminal value; sampled every cycle
mode  input  1  0 = wrap (free-running), 1 = one-shot (stop at limit)
clear_ovf  input  1  synchronous clear of ovf
count  output  WIDTH  current count (registered)
tc  output  1  terminal-count pulse (registered)
done  output  1  one-shot finished flag (registered, sticky)
ovf  output  1  wrap-occurred flag (registered, sticky)

Behaviour:
- Reset (asynchronous, active-high): count=0, tc=0, done=0, ovf=0, state=RUN.
  - Outputs take these values immediately on reset assertion, with no clock edge required.
  - Held while reset=1.
- State machine: RUN, HOLD.
  - RUN -> HOLD: the edge at which a one-shot terminal event occurs.
  - HOLD -> RUN: only on load or reset.
- Terminal condition: count >= limit (unsigned compare). This covers a loaded value above limit.
- Per rising edge, in priority order:
  1. load=1: count<=load_value; state<=RUN; done<=0; tc<=0. enable is ignored this cycle.
  2. state=RUN, enable=1, terminal condition false: count<=count+1; tc<=0.
  3. state=RUN, enable=1, terminal condition true, mode=0: count<=0; tc<=1; ovf<=1.
  4. state=RUN, enable=1, terminal condition true, mode=1: count holds; tc<=1; done<=1; state<=HOLD.
  5. Otherwise (enable=0, or state=HOLD): count holds; tc<=0.
- tc: high for exactly one cycle after each terminal edge; never high two cycles in a row unless terminal edges are consecutive.
- ovf:
  - Set by the wrap in case 3.
  - Cleared by clear_ovf=1 at an edge.
  - If a wrap and clear_ovf occur on the same edge, set wins and ovf=1.
  - Unaffected by load.
- done: cleared only by load or reset. In HOLD, enable has no effect.
- Arithmetic: WIDTH-bit unsigned. Increment never exceeds limit, so there is no silent modulo-2^WIDTH wrap.
  - limit = 2^WIDTH-1 gives full-range counting; the wrap is via case 3.
- limit=0, mode=0: count stays 0; tc=1 on every enabled cycle; ovf sets.
- limit=0, mode=1: first enabled edge enters HOLD with done=1.
- limit changes take effect on the next edge's compare. Lowering limit below the current count triggers the terminal event on the next enabled edge.
- mode changes take effect on the next edge. Changing mode while in HOLD does not leave HOLD.
- Reset mid-count or in HOLD returns everything to the reset state asynchronously. The first enabled edge after deassertion gives count=1.

Test Plan:
- Wrap counting (WIDTH=4, limit=9, mode=0): reset 10ns, then enable=1 continuously -> count goes 0,1..9,0,1; tc=1 only in the cycle after 9->0; ovf=1 from then on.
- One-shot (limit=5, mode=1, enable=1): count 0..5, then holds at 5 for 10+ cycles; tc pulses once; done=1 and stays; then load=1 with load_value=2 -> count=2, done=0, counting resumes to 5.
- Priority (limit=15): load=1, load_value=12, enable=1 on the same edge -> count=12 (not 13). Next enabled edges -> 13,14,15,0 with tc pulse; confirms full-range wrap.
- Asynchronous reset: assert reset mid-edge-cycle at count=7 -> count=0, tc/done/ovf=0 before the next clk edge. Deassert -> first enabled edge gives count=1.
- Sticky flag: clear_ovf=1 coincident with a wrap edge -> ovf=1. clear_ovf=1 on a non-wrap edge -> ovf=0. load does not change ovf.
- Boundaries:
  - limit=0, mode=0 -> count=0 and tc=1 on every enabled cycle.
  - load_value=10 with limit=4, mode=0 -> next enabled edge wraps count to 0 with a tc pulse.
  - enable=0 for 5 cycles -> count is frozen and tc=0.
